// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; drives a valid/ready data-memory port and registers the WB record.
// Latency: 1 cycle for ALU pass-through and zero-wait accesses; +1 per cycle d_ready stays low.
// Backpressure: stall_MEM = d_req & ~d_ready freezes IF/ID/EX; optional MEM_TIMEOUT_EN aborts long waits.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ALU_out_MEM,
  input  logic [31:0] S2_MEM,
  input  logic        d_write_enable_MEM,
  input  logic        d_load_enable_MEM,
  input  logic [4:0]  Rd_MEM,
  output logic [31:0] ALU_out_MEM_backward,
  output logic [4:0]  Rd_MEM_backward,
  output logic        stall_MEM,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_req,
  output logic        d_we,
  input  logic        d_ready,
  input  logic [31:0] d_rdata,
  output logic [31:0] wb_data_WB,
  output logic [4:0]  Rd_WB,
  output logic        wb_enable_WB,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state;
  state_t state_next;
  logic   access;
  logic   complete;
  logic   abort;

  assign access = d_write_enable_MEM | d_load_enable_MEM;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The request cycle plus (TIMEOUT_CYCLES-1) WAIT cycles stall; the next WAIT cycle aborts.
  assign abort = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !d_ready;

  // Wait-cycle counter: counts WAIT cycles, cleared whenever the FSM heads back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state_next == IDLE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flag: set by any aborted access, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_err <= 1'b0;
    end else if (abort) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: leave IDLE only when the request is not accepted at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (d_req && !d_ready) state_next = WAIT;
      WAIT:    if (d_ready || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: reset gates d_req so an abandoned access drops the port instantly.
  always_comb begin
    d_req                = reset_n & ~abort & ((state == WAIT) | access);
    d_we                 = d_write_enable_MEM;
    d_addr               = ALU_out_MEM;
    d_wdata              = S2_MEM;
    stall_MEM            = d_req & ~d_ready;
    complete             = d_req & d_ready;
    ALU_out_MEM_backward = ALU_out_MEM;
    // A load/store carries an address in ALU_out_MEM, never a result.
    Rd_MEM_backward      = access ? 5'd0 : Rd_MEM;
  end

  // Write-back record: bubble on stall/abort, load data or nothing on completion, else pass-through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_data_WB   <= 32'd0;
      Rd_WB        <= 5'd0;
      wb_enable_WB <= 1'b0;
    end else if (stall_MEM || abort) begin
      Rd_WB        <= 5'd0;
      wb_enable_WB <= 1'b0;
    end else if (complete) begin
      if (d_write_enable_MEM) begin
        Rd_WB        <= 5'd0;
        wb_enable_WB <= 1'b0;
      end else begin
        wb_data_WB   <= d_rdata;
        Rd_WB        <= Rd_MEM;
        wb_enable_WB <= (Rd_MEM != 5'd0);
      end
    end else begin
      wb_data_WB   <= ALU_out_MEM;
      Rd_WB        <= Rd_MEM;
      wb_enable_WB <= (Rd_MEM != 5'd0);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: WB records are queued at issue and checked by a negedge monitor.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ALU_out_MEM, S2_MEM, d_rdata;
  logic        d_write_enable_MEM, d_load_enable_MEM, d_ready;
  logic [4:0]  Rd_MEM;
  logic [31:0] ALU_out_MEM_backward, d_addr, d_wdata, wb_data_WB;
  logic [4:0]  Rd_MEM_backward, Rd_WB;
  logic        stall_MEM, d_req, d_we, wb_enable_WB, mem_err;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];   // {rd, data}

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ALU_out_MEM(ALU_out_MEM), .S2_MEM(S2_MEM),
    .d_write_enable_MEM(d_write_enable_MEM), .d_load_enable_MEM(d_load_enable_MEM),
    .Rd_MEM(Rd_MEM),
    .ALU_out_MEM_backward(ALU_out_MEM_backward), .Rd_MEM_backward(Rd_MEM_backward),
    .stall_MEM(stall_MEM), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_req(d_req), .d_we(d_we), .d_ready(d_ready), .d_rdata(d_rdata),
    .wb_data_WB(wb_data_WB), .Rd_WB(Rd_WB), .wb_enable_WB(wb_enable_WB),
    .mem_err(mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] s2, input logic we,
                       input logic le, input logic [4:0] rd, input logic rdy, input logic [31:0] rdata);
    ALU_out_MEM        = alu;
    S2_MEM             = s2;
    d_write_enable_MEM = we;
    d_load_enable_MEM  = le;
    Rd_MEM             = rd;
    d_ready            = rdy;
    d_rdata            = rdata;
  endtask

  // Monitor: every write-back strobe must match the oldest queued expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (wb_enable_WB === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%h, expected no write-back", Rd_WB, wb_data_WB);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", {27'd0, Rd_WB}, {27'd0, e[36:32]});
          chk("wb_data", wb_data_WB, e[31:0]);
        end
      end
    end
  end

  initial begin
    int stalls;
    reset_n = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_data", wb_data_WB, 32'd0);
    chk("rst_rd_wb", {27'd0, Rd_WB}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_enable_WB}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_d_req", {31'd0, d_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: ALU pass-through
    @(posedge clk); #1;
    drive(32'h0000_1234, 32'd0, 1'b0, 1'b0, 5'd5, 1'b0, 32'd0);
    exp_q.push_back({5'd5, 32'h0000_1234});
    @(negedge clk);
    chk("t1_d_req", {31'd0, d_req}, 32'd0);
    chk("t1_stall", {31'd0, stall_MEM}, 32'd0);
    chk("t1_rd_back", {27'd0, Rd_MEM_backward}, 32'd5);
    chk("t1_alu_back", ALU_out_MEM_backward, 32'h0000_1234);

    // 2: zero-wait load
    @(posedge clk); #1;
    drive(32'h100, 32'd0, 1'b0, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF);
    exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("t2_d_req", {31'd0, d_req}, 32'd1);
    chk("t2_d_we", {31'd0, d_we}, 32'd0);
    chk("t2_stall", {31'd0, stall_MEM}, 32'd0);
    chk("t2_addr", d_addr, 32'h100);
    chk("t2_rd_back", {27'd0, Rd_MEM_backward}, 32'd0);
    @(posedge clk); #1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);

    // 3: store, d_ready low for 3 cycles then high
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(32'h200, 32'hA5A5_A5A5, 1'b1, 1'b0, 5'd12, (i == 3), 32'd0);
      @(negedge clk);
      chk("t3_d_req", {31'd0, d_req}, 32'd1);
      chk("t3_d_we", {31'd0, d_we}, 32'd1);
      chk("t3_wdata", d_wdata, 32'hA5A5_A5A5);
      if (stall_MEM) stalls++;
      if (i > 0) chk("t3_bubble_en", {31'd0, wb_enable_WB}, 32'd0);
    end
    @(posedge clk); #1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("t3_stall_cycles", stalls, 32'd3);
    chk("t3_done_en", {31'd0, wb_enable_WB}, 32'd0);
    chk("t3_done_rd", {27'd0, Rd_WB}, 32'd0);

    // 4: load to r0 with one wait cycle
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(32'h300, 32'd0, 1'b0, 1'b1, 5'd0, (i == 1), 32'h1111_2222);
      @(negedge clk);
      if (stall_MEM) stalls++;
    end
    @(posedge clk); #1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("t4_stall_cycles", stalls, 32'd1);
    chk("t4_wb_en", {31'd0, wb_enable_WB}, 32'd0);

    // 5: reset during WAIT (ALU op first so wb_data is non-zero)
    drive(32'h55, 32'd0, 1'b0, 1'b0, 5'd9, 1'b0, 32'd0);
    exp_q.push_back({5'd9, 32'h55});
    @(posedge clk); #1;
    drive(32'h400, 32'd0, 1'b0, 1'b1, 5'd3, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_wait_stall", {31'd0, stall_MEM}, 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_d_req", {31'd0, d_req}, 32'd0);
    chk("t5_stall", {31'd0, stall_MEM}, 32'd0);
    chk("t5_wb_data", wb_data_WB, 32'd0);
    chk("t5_rd_wb", {27'd0, Rd_WB}, 32'd0);
    chk("t5_wb_en", {31'd0, wb_enable_WB}, 32'd0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(32'h500, 32'd0, 1'b0, 1'b1, 5'd8, 1'b1, 32'hCAFE_F00D);
    exp_q.push_back({5'd8, 32'hCAFE_F00D});
    @(negedge clk);
    chk("t5_post_stall", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // 6: timeout abort after 4 stall cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) drive(32'h600, 32'd0, 1'b0, 1'b1, 5'd4, 1'b0, 32'd0);
      @(negedge clk);
      chk("t6_stall", {31'd0, stall_MEM}, (i < 4) ? 32'd1 : 32'd0);
      chk("t6_d_req", {31'd0, d_req}, (i < 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(32'h77, 32'd0, 1'b0, 1'b0, 5'd6, 1'b0, 32'd0);
    exp_q.push_back({5'd6, 32'h77});
    @(negedge clk);
    chk("t6_mem_err", {31'd0, mem_err}, 32'd1);
    chk("t6_abort_en", {31'd0, wb_enable_WB}, 32'd0);
    @(posedge clk); #1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_mem_err_sticky", {31'd0, mem_err}, 32'd1);
`else
    chk("mem_err_tied", {31'd0, mem_err}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
